// File: rtl/fib_insert_engine_pkg.sv
// Shared definitions for the FIB write (insert) engine and the FIB lookup engine.
// Holds the table geometry, the packed entry layout, the op and status encodings,
// and the mask/hash helpers. Both engines must use these helpers so that their
// probe sequences agree.
package fib_insert_engine_pkg;

    localparam int PREFIX_W  = 64;   // name prefix width, MSB-aligned
    localparam int LEN_W     = 5;    // length field; valid prefix bits = 2*len
    localparam int IDX_W     = 10;   // table index width (2^IDX_W slots)
    localparam int PORT_W    = 4;    // next-hop face id width
    localparam int MAX_PROBE = 8;    // slots probed per request before giving up
    localparam int PROBE_W   = $clog2(MAX_PROBE + 1);
    localparam int ENT_W     = 2 + LEN_W + PREFIX_W + PORT_W;
    localparam int N_SLICES  = (PREFIX_W + IDX_W - 1) / IDX_W;

    // Entry layout, MSB first: {valid, tomb, len, prefix, port}
    typedef struct packed {
        logic                valid;
        logic                tomb;
        logic [LEN_W-1:0]    len;
        logic [PREFIX_W-1:0] prefix;
        logic [PORT_W-1:0]   port;
    } fib_entry_t;

    localparam int ENT_PORT_LSB   = 0;
    localparam int ENT_PREFIX_LSB = PORT_W;
    localparam int ENT_LEN_LSB    = PORT_W + PREFIX_W;
    localparam int ENT_TOMB_BIT   = PORT_W + PREFIX_W + LEN_W;
    localparam int ENT_VALID_BIT  = ENT_TOMB_BIT + 1;

    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_DELETE = 2'b01,
        OP_RSVD   = 2'b10,
        OP_CLEAR  = 2'b11
    } fib_op_e;

    typedef enum logic [2:0] {
        ST_NEW       = 3'd0,
        ST_UPDATED   = 3'd1,
        ST_DELETED   = 3'd2,
        ST_NOT_FOUND = 3'd3,
        ST_FULL      = 3'd4,
        ST_CLEARED   = 3'd5,
        ST_BADOP     = 3'd6
    } fib_status_e;

    // Keep only the top 2*len bits of the prefix (len = 0 -> all zero).
    function automatic logic [PREFIX_W-1:0] fib_mask(input logic [PREFIX_W-1:0] prefix,
                                                     input logic [LEN_W-1:0]    len);
        logic [PREFIX_W-1:0] keep;
        keep = ~({PREFIX_W{1'b1}} >> {len, 1'b0});
        return prefix & keep;
    endfunction

    // XOR-fold of IDX_W-bit slices of the masked prefix (the top slice is
    // zero-padded) with the zero-extended length.
    function automatic logic [IDX_W-1:0] fib_hash(input logic [PREFIX_W-1:0] masked,
                                                  input logic [LEN_W-1:0]    len);
        logic [N_SLICES*IDX_W-1:0] padded;
        logic [IDX_W-1:0]          h;
        padded                 = '0;
        padded[PREFIX_W-1:0]   = masked;
        h                      = '0;
        h[LEN_W-1:0]           = len;
        for (int s = 0; s < N_SLICES; s++) begin
            h = h ^ padded[s*IDX_W +: IDX_W];
        end
        return h;
    endfunction

endpackage

// File: rtl/fib_insert_engine_if.sv
// Request/response and FIB RAM port bundle of the insert engine.
//   slave  : engine side (takes requests, drives the RAM port)
//   master : environment side (route management, RAM model, lookup arbiter)
interface fib_insert_engine_if;
    import fib_insert_engine_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [PREFIX_W-1:0] req_prefix;
    logic [LEN_W-1:0]    req_len;
    logic [PORT_W-1:0]   req_port;

    logic                resp_valid;
    logic [2:0]          resp_status;
    logic [IDX_W-1:0]    resp_idx;

    logic                lookup_busy;
    logic [IDX_W-1:0]    mem_addr;
    logic                mem_re;
    logic                mem_we;
    logic [ENT_W-1:0]    mem_wdata;
    logic [ENT_W-1:0]    mem_rdata;

    modport slave (
        input  req_valid, req_op, req_prefix, req_len, req_port, lookup_busy, mem_rdata,
        output req_ready, resp_valid, resp_status, resp_idx, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_prefix, req_len, req_port, lookup_busy, mem_rdata,
        input  req_ready, resp_valid, resp_status, resp_idx, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/fib_insert_engine_hash_fold.sv
// fib_hash_fold: combinational prefix mask + hash fold, shared by the insert and
// lookup engines.
//   i_prefix : raw prefix (MSB-aligned)
//   i_len    : prefix length (valid bits = 2*len)
//   o_masked : prefix with bits below 2*len cleared
//   o_hash   : home slot of the prefix
module fib_hash_fold
    import fib_insert_engine_pkg::*;
(
    input  logic [PREFIX_W-1:0] i_prefix,
    input  logic [LEN_W-1:0]    i_len,
    output logic [PREFIX_W-1:0] o_masked,
    output logic [IDX_W-1:0]    o_hash
);

    logic [PREFIX_W-1:0] w_masked;

    assign w_masked = fib_mask(i_prefix, i_len);
    assign o_masked = w_masked;
    assign o_hash   = fib_hash(w_masked, i_len);

endmodule

// File: rtl/fib_insert_engine.sv
// fib_insert_engine: write side of the FIB hash table. Serialises insert/update,
// delete and clear requests into the shared FIB entry RAM using linear probing
// with tombstones, yielding the RAM to the lookup engine whenever lookup_busy.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : req_valid/req_ready/req_op/req_prefix/req_len/req_port request,
//                 resp_valid/resp_status/resp_idx completion pulse,
//                 lookup_busy, mem_addr/mem_re/mem_we/mem_wdata/mem_rdata RAM port
//                 (registered read: mem_rdata valid the cycle after mem_re)
module fib_insert_engine
    import fib_insert_engine_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fib_insert_engine_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_HASH, S_RD, S_CMP, S_WR, S_CLR, S_RESP
    } state_e;

    state_e              r_state, r_state_next;
    fib_op_e             r_op, r_op_next;
    logic [PREFIX_W-1:0] r_prefix, r_prefix_next;
    logic [LEN_W-1:0]    r_len, r_len_next;
    logic [PORT_W-1:0]   r_port, r_port_next;
    logic [IDX_W-1:0]    r_hash, r_hash_next;
    logic [PROBE_W-1:0]  r_probe, r_probe_next;
    logic                r_have_free, r_have_free_next;
    logic [IDX_W-1:0]    r_free_idx, r_free_idx_next;
    logic [IDX_W-1:0]    r_wr_addr, r_wr_addr_next;
    fib_entry_t          r_wr_entry, r_wr_entry_next;
    logic [2:0]          r_status, r_status_next;
    logic [IDX_W-1:0]    r_idx, r_idx_next;
    logic [IDX_W-1:0]    r_clr_idx, r_clr_idx_next;

    logic [PREFIX_W-1:0] w_masked;
    logic [IDX_W-1:0]    w_hash;
    logic [IDX_W-1:0]    w_probe_addr;
    fib_entry_t          w_rd;
    fib_entry_t          w_ins_entry;
    fib_entry_t          w_tomb_entry;
    logic                w_match, w_empty, w_slot_free, w_free_any, w_last;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_unused_port;

    // Mask and hash are derived from the latched raw request.
    fib_hash_fold u_fold (
        .i_prefix (r_prefix),
        .i_len    (r_len),
        .o_masked (w_masked),
        .o_hash   (w_hash)
    );

    assign w_probe_addr = r_hash + IDX_W'(r_probe);   // wraps at the top of the table
    assign w_rd         = fib_entry_t'(bus.mem_rdata);
    assign w_unused_port = ^w_rd.port;

    assign w_match     = w_rd.valid && (w_rd.len == r_len) && (w_rd.prefix == w_masked);
    assign w_empty     = !w_rd.valid && !w_rd.tomb;
    assign w_slot_free = !w_rd.valid;                  // empty or tombstone
    // First reusable slot along the chain, including the slot being compared now.
    assign w_free_any  = r_have_free || w_slot_free;
    assign w_free_idx  = r_have_free ? r_free_idx : w_probe_addr;
    assign w_last      = (r_probe == PROBE_W'(MAX_PROBE - 1));

    always_comb begin
        w_ins_entry        = '0;
        w_ins_entry.valid  = 1'b1;
        w_ins_entry.len    = r_len;
        w_ins_entry.prefix = w_masked;
        w_ins_entry.port   = r_port;
        w_tomb_entry       = '0;
        w_tomb_entry.tomb  = 1'b1;
    end

    // Strobes are gated by rst so an in-flight request stops touching RAM at once.
    assign bus.req_ready   = (r_state == S_IDLE) && !rst;
    assign bus.resp_valid  = (r_state == S_RESP) && !rst;
    assign bus.resp_status = r_status;
    assign bus.resp_idx    = r_idx;
    assign bus.mem_re      = (r_state == S_RD) && !bus.lookup_busy && !rst;
    assign bus.mem_we      = ((r_state == S_WR) || (r_state == S_CLR)) && !bus.lookup_busy && !rst;
    assign bus.mem_addr    = (r_state == S_RD)  ? w_probe_addr :
                             (r_state == S_WR)  ? r_wr_addr    :
                             (r_state == S_CLR) ? r_clr_idx    : '0;
    assign bus.mem_wdata   = (r_state == S_WR)  ? r_wr_entry   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_INSERT;
            r_prefix    <= '0;
            r_len       <= '0;
            r_port      <= '0;
            r_hash      <= '0;
            r_probe     <= '0;
            r_have_free <= 1'b0;
            r_free_idx  <= '0;
            r_wr_addr   <= '0;
            r_wr_entry  <= '0;
            r_status    <= '0;
            r_idx       <= '0;
            r_clr_idx   <= '0;
        end else begin
            r_state     <= r_state_next;
            r_op        <= r_op_next;
            r_prefix    <= r_prefix_next;
            r_len       <= r_len_next;
            r_port      <= r_port_next;
            r_hash      <= r_hash_next;
            r_probe     <= r_probe_next;
            r_have_free <= r_have_free_next;
            r_free_idx  <= r_free_idx_next;
            r_wr_addr   <= r_wr_addr_next;
            r_wr_entry  <= r_wr_entry_next;
            r_status    <= r_status_next;
            r_idx       <= r_idx_next;
            r_clr_idx   <= r_clr_idx_next;
        end
    end

    always_comb begin
        r_state_next     = r_state;
        r_op_next        = r_op;
        r_prefix_next    = r_prefix;
        r_len_next       = r_len;
        r_port_next      = r_port;
        r_hash_next      = r_hash;
        r_probe_next     = r_probe;
        r_have_free_next = r_have_free;
        r_free_idx_next  = r_free_idx;
        r_wr_addr_next   = r_wr_addr;
        r_wr_entry_next  = r_wr_entry;
        r_status_next    = r_status;
        r_idx_next       = r_idx;
        r_clr_idx_next   = r_clr_idx;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    r_op_next        = fib_op_e'(bus.req_op);
                    r_prefix_next    = bus.req_prefix;
                    r_len_next       = bus.req_len;
                    r_port_next      = bus.req_port;
                    r_probe_next     = '0;
                    r_have_free_next = 1'b0;
                    r_free_idx_next  = '0;
                    r_clr_idx_next   = '0;
                    case (fib_op_e'(bus.req_op))
                        OP_CLEAR: r_state_next = S_CLR;
                        OP_RSVD: begin
                            r_status_next = ST_BADOP;
                            r_idx_next    = '0;
                            r_state_next  = S_RESP;
                        end
                        default:  r_state_next = S_HASH;
                    endcase
                end
            end

            S_HASH: begin
                r_hash_next  = w_hash;
                r_state_next = S_RD;
            end

            S_RD: begin
                if (!bus.lookup_busy) begin
                    r_state_next = S_CMP;
                end
            end

            S_CMP: begin
                if (w_match) begin
                    r_wr_addr_next  = w_probe_addr;
                    r_idx_next      = w_probe_addr;
                    r_wr_entry_next = (r_op == OP_INSERT) ? w_ins_entry : w_tomb_entry;
                    r_status_next   = (r_op == OP_INSERT) ? ST_UPDATED : ST_DELETED;
                    r_state_next    = S_WR;
                end else if ((w_empty || w_last) && (r_op == OP_INSERT) && w_free_any) begin
                    // End of chain (or probe budget): place the new entry in the
                    // first reusable slot seen.
                    r_wr_addr_next  = w_free_idx;
                    r_idx_next      = w_free_idx;
                    r_wr_entry_next = w_ins_entry;
                    r_status_next   = ST_NEW;
                    r_state_next    = S_WR;
                end else if (w_empty || w_last) begin
                    r_idx_next    = '0;
                    r_status_next = (r_op == OP_INSERT) ? ST_FULL : ST_NOT_FOUND;
                    r_state_next  = S_RESP;
                end else begin
                    r_probe_next = r_probe + PROBE_W'(1);
                    if (w_slot_free && !r_have_free) begin
                        r_have_free_next = 1'b1;
                        r_free_idx_next  = w_probe_addr;
                    end
                    r_state_next = S_RD;
                end
            end

            S_WR: begin
                if (!bus.lookup_busy) begin
                    r_state_next = S_RESP;
                end
            end

            S_CLR: begin
                // Stalled cycles leave the counter where it is.
                if (!bus.lookup_busy) begin
                    if (r_clr_idx == '1) begin
                        r_status_next = ST_CLEARED;
                        r_idx_next    = '0;
                        r_state_next  = S_RESP;
                    end else begin
                        r_clr_idx_next = r_clr_idx + IDX_W'(1);
                    end
                end
            end

            S_RESP: begin
                r_state_next = S_IDLE;
            end

            default: begin
                r_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fib_insert_engine.sv
module tb_fib_insert_engine;
    import fib_insert_engine_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fib_insert_engine_if bus();

    fib_insert_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 1-cycle registered-read RAM
    logic [74:0] ram [0:1023];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference table contents
    logic [74:0] mdl [0:1023];

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: RAM strobes exclusive and silent while the lookup engine owns RAM.
    always @(negedge clk) begin
        #1;
        if (bus.mem_we) we_count++;
        if (!rst && (bus.mem_re || bus.mem_we || bus.lookup_busy)) begin
            checks++;
            if ((bus.mem_re && bus.mem_we) || (bus.lookup_busy && (bus.mem_re || bus.mem_we))) begin
                errors++;
                $display("FAIL strobe_rule: re=%0b we=%0b busy=%0b, required no overlap", bus.mem_re, bus.mem_we, bus.lookup_busy);
            end
        end
    end

    function automatic logic [63:0] m_mask(input logic [4:0] len);
        logic [63:0] m;
        m = '0;
        for (int j = 0; j < 64; j++) if (j >= 64 - 2 * int'(len)) m[j] = 1'b1;
        return m;
    endfunction

    // Bit j of the masked prefix lands on hash bit j mod 10.
    function automatic logic [9:0] m_hash(input logic [63:0] p, input logic [4:0] len);
        logic [63:0] mp;
        logic [9:0]  h;
        mp = p & m_mask(len);
        h  = {5'd0, len};
        for (int j = 0; j < 64; j++) h[j % 10] = h[j % 10] ^ mp[j];
        return h;
    endfunction

    // Prefix of length 31 whose home slot is target (slice bits 19:10 chosen to cancel).
    function automatic logic [63:0] make_pfx(input int seed, input logic [9:0] target);
        logic [63:0] p;
        p = {32'(seed), 12'h5A5, 20'h0};
        p[19:10] = m_hash(p, 5'd31) ^ target;
        return p;
    endfunction

    task automatic model_req(input logic [1:0] op, input logic [63:0] pfx, input logic [4:0] len,
                             input logic [3:0] port, output logic [2:0] st, output logic [9:0] idx,
                             output int probes, output bit wrote);
        logic [63:0] mp;
        logic [9:0]  h, a, fidx;
        logic [74:0] e;
        bit hf, done;
        mp = pfx & m_mask(len);
        h  = m_hash(pfx, len);
        st = 3'd0; idx = '0; probes = 0; wrote = 1'b0; hf = 1'b0; fidx = '0; done = 1'b0;
        if (op == 2'b11) begin
            for (int i = 0; i < 1024; i++) mdl[i] = '0;
            st = 3'd5;
            return;
        end
        if (op == 2'b10) begin
            st = 3'd6;
            return;
        end
        for (int i = 0; i < 8 && !done; i++) begin
            a = h + 10'(i);
            e = mdl[a];
            probes = i + 1;
            if (e[74] && e[72:68] == len && e[67:4] == mp) begin
                if (op == 2'b00) begin mdl[a] = {1'b1, 1'b0, len, mp, port}; st = 3'd1; end
                else begin mdl[a] = {1'b0, 1'b1, 73'd0}; st = 3'd2; end
                idx = a; wrote = 1'b1; done = 1'b1;
            end else if (!e[74] && !e[73]) begin
                if (op == 2'b00) begin
                    if (!hf) fidx = a;
                    mdl[fidx] = {1'b1, 1'b0, len, mp, port};
                    st = 3'd0; idx = fidx; wrote = 1'b1;
                end else begin
                    st = 3'd3;
                end
                done = 1'b1;
            end else if (!e[74] && !hf) begin
                hf = 1'b1; fidx = a;
            end
        end
        if (!done) begin
            if (op == 2'b00 && hf) begin
                mdl[fidx] = {1'b1, 1'b0, len, mp, port};
                st = 3'd0; idx = fidx; wrote = 1'b1;
            end else begin
                st = (op == 2'b00) ? 3'd4 : 3'd3;
            end
        end
    endtask

    task automatic cmp_table(input string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < 1024; i++) if (ram[i] !== mdl[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s table[%0d]: got %0h, expected %0h", tag, bad, ram[bad], mdl[bad]);
        end
    endtask

    // One request; lookup_busy held for cycles T+bfrom..T+bfrom+blen-1 (T = accept cycle).
    task automatic do_req(input string tag, input logic [1:0] op, input logic [63:0] pfx,
                          input logic [4:0] len, input logic [3:0] port, input int bfrom,
                          input int blen, input int extra,
                          output logic [2:0] act_st, output logic [9:0] act_idx);
        logic [2:0] est;
        logic [9:0] eidx;
        int probes, elat, n, w;
        bit wrote, got;
        model_req(op, pfx, len, port, est, eidx, probes, wrote);
        case (op)
            2'b10:   elat = 1;
            2'b11:   elat = 1025;
            default: elat = wrote ? 2 * probes + 3 : 2 * probes + 2;
        endcase
        elat += extra;
        act_st = 'x; act_idx = 'x;
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
        chk({tag, "_ready"}, bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_prefix = pfx;
        bus.req_len    = len;
        bus.req_port   = port;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1; got = 1'b0;
        while (n <= elat + 20) begin
            bus.lookup_busy = (n >= bfrom) && (n < bfrom + blen);
            #1;
            if (bus.resp_valid) begin got = 1'b1; break; end
            @(negedge clk);
            n++;
        end
        bus.lookup_busy = 1'b0;
        chk({tag, "_resp_seen"}, got, 1'b1);
        if (got) begin
            act_st  = bus.resp_status;
            act_idx = bus.resp_idx;
            chk({tag, "_status"}, bus.resp_status, est);
            chk({tag, "_idx"}, bus.resp_idx, eidx);
            chk({tag, "_latency"}, n, elat);
        end
        @(negedge clk);
        #1;
        chk({tag, "_pulse"}, bus.resp_valid, 1'b0);
        cmp_table(tag);
        $display("txn %s op=%0d status=%0d idx=%0d latency=%0d", tag, op, act_st, act_idx, n);
    endtask

    logic [63:0] cp [1:10];
    logic [2:0]  s;
    logic [9:0]  x;
    int          we0;
    bit          seen;

    initial begin
        for (int i = 0; i < 1024; i++) begin ram[i] = '0; mdl[i] = '0; end
        for (int k = 1; k <= 10; k++) cp[k] = make_pfx(k, 10'd1020);
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_prefix = '0;
        bus.req_len = '0; bus.req_port = '0; bus.lookup_busy = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_strobes", {bus.mem_re, bus.mem_we}, 2'b00);
        chk("rst_status_idx", {bus.resp_status, bus.resp_idx}, 13'd0);
        chk("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 85'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.req_ready, 1'b1);

        // Insert into empty table: home slot 0x2CE = 718
        do_req("ins_ab", 2'b00, 64'hAB00_0000_0000_0000, 5'd4, 4'd3, 0, 0, 0, s, x);
        chk("ins_ab_lit", {s, x}, {3'd0, 10'd718});
        chk("ins_ab_entry", ram[718], {1'b1, 1'b0, 5'd4, 64'hAB00_0000_0000_0000, 4'd3});
        do_req("upd_ab", 2'b00, 64'hABFF_1234_0000_0000, 5'd4, 4'd7, 0, 0, 0, s, x);
        chk("upd_ab_lit", {s, x}, {3'd1, 10'd718});
        chk("upd_ab_port", ram[718][3:0], 4'd7);

        // Nine colliding prefixes at slot 1020: chain wraps, ninth is FULL
        for (int k = 1; k <= 9; k++) begin
            do_req($sformatf("coll%0d", k), 2'b00, cp[k], 5'd31, 4'(k), 0, 0, 0, s, x);
            if (k <= 8) chk($sformatf("coll%0d_lit", k), {s, x}, {3'd0, 10'(1019 + k)});
            else        chk("coll9_lit", {s, x}, {3'd4, 10'd0});
        end

        // Tombstone: skipped on search, reused on insert
        do_req("del3", 2'b01, cp[3], 5'd31, 4'd0, 0, 0, 0, s, x);
        chk("del3_lit", {s, x}, {3'd2, 10'd1022});
        do_req("upd5", 2'b00, cp[5], 5'd31, 4'd9, 0, 0, 0, s, x);
        chk("upd5_lit", {s, x}, {3'd1, 10'd0});
        do_req("ins10", 2'b00, cp[10], 5'd31, 4'd10, 0, 0, 0, s, x);
        chk("ins10_lit", {s, x}, {3'd0, 10'd1022});
        do_req("del_miss", 2'b01, 64'h1234_0000_0000_0000, 5'd8, 4'd0, 0, 0, 0, s, x);
        chk("del_miss_lit", {s, x}, {3'd3, 10'd0});
        do_req("badop", 2'b10, 64'h0, 5'd0, 4'd0, 0, 0, 0, s, x);
        chk("badop_lit", {s, x}, {3'd6, 10'd0});

        // lookup_busy for 3 cycles in RD, then in WR
        do_req("stall_rd", 2'b00, 64'hC0DE_0000_0000_0000, 5'd8, 4'd1, 2, 3, 3, s, x);
        do_req("stall_wr", 2'b00, 64'hBEEF_0000_0000_0000, 5'd12, 4'd2, 4, 3, 3, s, x);

        // Reset asserted during CMP: nothing written, no response
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_prefix = 64'hFACE_0000_0000_0000;
        bus.req_len = 5'd8; bus.req_port = 4'd5;
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        we0 = we_count; seen = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1; if (bus.resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_cmp_no_we", we_count - we0, 0);
        chk("rst_cmp_no_resp", seen, 1'b0);
        chk("rst_cmp_ready", bus.req_ready, 1'b1);
        cmp_table("rst_cmp");

        // Clear with a 3-cycle stall
        we0 = we_count;
        do_req("clear", 2'b11, 64'h0, 5'd0, 4'd0, 10, 3, 3, s, x);
        chk("clear_lit", {s, x}, {3'd5, 10'd0});
        chk("clear_writes", we_count - we0, 1024);
        chk("clear_slot718", ram[718], 75'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
